// File: rtl/alu_pkg.sv
// Shared definitions for the ALU execution unit.
//   - default operand / shift-amount widths
//   - bit positions of the one-hot ctrl_sig op select
//   - FSM state encoding
//   - one-hot legality helper
package alu_pkg;

  localparam int DATA_W_DEF  = 32;
  localparam int SHAMT_W_DEF = 5;
  localparam int NUM_OPS     = 6;

  // ctrl_sig bit positions
  localparam int OP_ADD = 0;
  localparam int OP_SUB = 1;
  localparam int OP_AND = 2;
  localparam int OP_OR  = 3;
  localparam int OP_SLL = 4;
  localparam int OP_SRA = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } alu_state_e;

  // True when exactly one bit of the op select is set.
  function automatic logic is_onehot(input logic [NUM_OPS-1:0] v);
    int n;
    n = 0;
    for (int i = 0; i < NUM_OPS; i++)
      if (v[i]) n++;
    return (n == 1);
  endfunction

endpackage

// File: rtl/add_sub32.sv
// Combinational adder/subtractor with signed-overflow detection.
// Ports:
//   i_a, i_b  : operands
//   i_sub     : 0 = a+b, 1 = a-b
//   o_sum     : result modulo 2^DATA_W
//   o_ovf     : two's-complement overflow
module add_sub32
  import alu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  input  logic              i_sub,
  output logic [DATA_W-1:0] o_sum,
  output logic              o_ovf
);

  logic [DATA_W-1:0] w_b;
  logic              w_sa, w_sb, w_sr;

  // Subtract as a + ~b + 1.
  assign w_b   = i_sub ? ~i_b : i_b;
  assign o_sum = i_a + w_b + {{(DATA_W-1){1'b0}}, i_sub};

  assign w_sa = i_a[DATA_W-1];
  assign w_sb = i_b[DATA_W-1];
  assign w_sr = o_sum[DATA_W-1];

  // ADD: like signs in, different sign out.
  // SUB: unlike signs in, result sign differs from a.
  assign o_ovf = i_sub ? ((w_sa != w_sb) && (w_sr != w_sa))
                       : ((w_sa == w_sb) && (w_sr != w_sa));

endmodule

// File: rtl/alu_exec_unit.sv
// ALU execution unit: single-issue, valid/ready handshake on both sides.
// ADD/SUB/AND/OR and zero-distance shifts complete in one cycle; SLL/SRA
// with a non-zero amount shift one bit per cycle. Illegal (non one-hot)
// op selects complete in one cycle with err=1.
// Ports:
//   clock, reset_n          : clock, async active-low reset
//   in_valid / in_ready     : request handshake
//   ctrl_sig                : one-hot op select
//   data_a, data_b, shamt   : operands and shift amount
//   out_valid / out_ready   : result handshake
//   result, isNotEqual, isLessThan, overflow, err : registered outputs
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int SHAMT_W = SHAMT_W_DEF
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [5:0]         ctrl_sig,
  input  logic [DATA_W-1:0]  data_a,
  input  logic [DATA_W-1:0]  data_b,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  result,
  output logic               isNotEqual,
  output logic               isLessThan,
  output logic               overflow,
  output logic               err
);

  alu_state_e         r_state, w_state_nxt;
  logic [DATA_W-1:0]  r_result, r_shreg;
  logic [SHAMT_W-1:0] r_cnt;
  logic               r_sra;
  logic               r_ne, r_lt, r_ovf, r_err;

  logic               w_legal, w_go_shift;
  logic [DATA_W-1:0]  w_sum, w_res, w_shift_nxt;
  logic               w_ovf_as;
  logic               w_ne, w_lt, w_ov, w_err;

  add_sub32 #(.DATA_W(DATA_W)) u_add_sub (
    .i_a   (data_a),
    .i_b   (data_b),
    .i_sub (ctrl_sig[OP_SUB]),
    .o_sum (w_sum),
    .o_ovf (w_ovf_as)
  );

  assign w_legal    = is_onehot(ctrl_sig);
  assign w_go_shift = w_legal && (ctrl_sig[OP_SLL] || ctrl_sig[OP_SRA]) &&
                      (shamt != '0);

  // Single-cycle result and flags; shifts with non-zero distance take the
  // iterative path and only borrow the (all-zero) flags from here.
  always_comb begin
    w_res = '0;
    w_ne  = 1'b0;
    w_lt  = 1'b0;
    w_ov  = 1'b0;
    w_err = 1'b0;
    if (!w_legal) begin
      w_err = 1'b1;
    end else if (ctrl_sig[OP_ADD] || ctrl_sig[OP_SUB]) begin
      w_res = w_sum;
      w_ov  = w_ovf_as;
      if (ctrl_sig[OP_SUB]) begin
        w_ne = |w_sum;
        w_lt = w_sum[DATA_W-1] ^ w_ovf_as;
      end
    end else if (ctrl_sig[OP_AND]) begin
      w_res = data_a & data_b;
    end else if (ctrl_sig[OP_OR]) begin
      w_res = data_a | data_b;
    end else begin
      w_res = data_a;  // SLL/SRA by zero
    end
  end

  assign w_shift_nxt = r_sra ? {r_shreg[DATA_W-1], r_shreg[DATA_W-1:1]}
                             : {r_shreg[DATA_W-2:0], 1'b0};

  // Next-state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (in_valid) w_state_nxt = w_go_shift ? ST_SHIFT : ST_DONE;
      ST_SHIFT: if (r_cnt == SHAMT_W'(1)) w_state_nxt = ST_DONE;
      ST_DONE:  if (out_ready) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Datapath. Result is written only when entering DONE, so it holds
  // through DONE regardless of input activity.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_result <= '0;
      r_shreg  <= '0;
      r_cnt    <= '0;
      r_sra    <= 1'b0;
      r_ne     <= 1'b0;
      r_lt     <= 1'b0;
      r_ovf    <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_ne  <= w_ne;
            r_lt  <= w_lt;
            r_ovf <= w_ov;
            r_err <= w_err;
            if (w_go_shift) begin
              r_shreg <= data_a;
              r_cnt   <= shamt;
              r_sra   <= ctrl_sig[OP_SRA];
            end else begin
              r_result <= w_res;
            end
          end
        end
        ST_SHIFT: begin
          r_shreg <= w_shift_nxt;
          r_cnt   <= r_cnt - SHAMT_W'(1);
          if (r_cnt == SHAMT_W'(1)) r_result <= w_shift_nxt;
        end
        default: ;
      endcase
    end
  end

  assign in_ready   = (r_state == ST_IDLE);
  assign out_valid  = (r_state == ST_DONE);
  assign result     = r_result;
  assign isNotEqual = r_ne;
  assign isLessThan = r_lt;
  assign overflow   = r_ovf;
  assign err        = r_err;

endmodule

// File: tb/tb_alu_exec_unit.sv
module tb_alu_exec_unit;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [5:0]  ctrl_sig = '0;
  logic [31:0] data_a = '0, data_b = '0;
  logic [4:0]  shamt = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result;
  logic        isNotEqual, isLessThan, overflow, err;

  alu_exec_unit dut (
    .clock(clock), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .ctrl_sig(ctrl_sig), .data_a(data_a), .data_b(data_b), .shamt(shamt),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .isNotEqual(isNotEqual), .isLessThan(isLessThan),
    .overflow(overflow), .err(err)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] res;
    logic ne, lt, ov, er;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  localparam logic [5:0] C_ADD = 6'b000001, C_SUB = 6'b000010,
                         C_AND = 6'b000100, C_OR  = 6'b001000,
                         C_SLL = 6'b010000, C_SRA = 6'b100000;

  function automatic exp_t mk(input logic [31:0] r, input logic ne,
                              input logic lt, input logic ov, input logic er);
    exp_t e;
    e.res = r; e.ne = ne; e.lt = lt; e.ov = ov; e.er = er;
    return e;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  // Monitor: one pop per DONE episode.
  bit seen = 1'b0;
  always @(negedge clock) begin
    exp_t e;
    if (!reset_n) seen = 1'b0;
    else if (out_valid && !seen) begin
      seen = 1'b1;
      if (sb.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_result got=%h want=none", result);
      end else begin
        e = sb.pop_front();
        check("result",     result,     e.res);
        check("isNotEqual", isNotEqual, e.ne);
        check("isLessThan", isLessThan, e.lt);
        check("overflow",   overflow,   e.ov);
        check("err",        err,        e.er);
      end
    end else if (!out_valid) seen = 1'b0;
  end

  // Issue one op, check latency and in_ready, optionally stall the consumer.
  task automatic do_op(input string nm, input logic [5:0] c, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] sh, input exp_t e,
                       input int lat, input int hold);
    int n;
    logic rdy_low;
    sb.push_back(e);
    ctrl_sig = c; data_a = a; data_b = b; shamt = sh; in_valid = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0;
    n = 1; rdy_low = 1'b1;
    while (!out_valid && n < 200) begin
      if (in_ready) rdy_low = 1'b0;
      @(posedge clock); #1;
      n++;
    end
    check({nm, "_latency"}, n, lat);
    check({nm, "_busy_not_ready"}, rdy_low, 1'b1);
    for (int i = 0; i < hold; i++) begin
      // Try to inject a request while the result is held.
      in_valid = 1'b1; ctrl_sig = C_ADD; data_a = 32'h1; data_b = 32'h1; shamt = 5'd0;
      @(posedge clock); #1;
      check({nm, "_hold_valid"},  out_valid,  1'b1);
      check({nm, "_hold_ready"},  in_ready,   1'b0);
      check({nm, "_hold_result"}, result,     e.res);
      check({nm, "_hold_flags"},  {isNotEqual, isLessThan, overflow, err},
                                  {e.ne, e.lt, e.ov, e.er});
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clock); #1;
    out_ready = 1'b0;
    check({nm, "_release_valid"}, out_valid, 1'b0);
    check({nm, "_release_ready"}, in_ready,  1'b1);
  endtask

  initial begin
    #12;
    check("rst_result", result, 32'h0);
    check("rst_flags",  {isNotEqual, isLessThan, overflow, err}, 4'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_in_ready",  in_ready,  1'b1);
    @(negedge clock);
    reset_n = 1'b1;

    do_op("add_ovf",  C_ADD, 32'h7FFFFFFF, 32'h1, 5'd0, mk(32'h80000000, 0, 0, 1, 0), 1, 0);
    do_op("sub_lt",   C_SUB, 32'd3, 32'd5, 5'd0, mk(32'hFFFFFFFE, 1, 1, 0, 0), 1, 0);
    do_op("sub_eq",   C_SUB, 32'd9, 32'd9, 5'd0, mk(32'h0, 0, 0, 0, 0), 1, 0);
    do_op("sub_min",  C_SUB, 32'h80000000, 32'h1, 5'd0, mk(32'h7FFFFFFF, 1, 1, 1, 0), 1, 0);
    do_op("sra4",     C_SRA, 32'h80000000, 32'h0, 5'd4, mk(32'hF8000000, 0, 0, 0, 0), 5, 0);
    do_op("sll0",     C_SLL, 32'h12345678, 32'h0, 5'd0, mk(32'h12345678, 0, 0, 0, 0), 1, 0);
    do_op("sll31",    C_SLL, 32'h00000003, 32'h0, 5'd31, mk(32'h80000000, 0, 0, 0, 0), 32, 0);
    do_op("or_hold",  C_OR,  32'hF0F00000, 32'h00000F0F, 5'd0, mk(32'hF0F00F0F, 0, 0, 0, 0), 1, 3);
    do_op("ill_zero", 6'b000000, 32'h5, 32'h6, 5'd0, mk(32'h0, 0, 0, 0, 1), 1, 0);
    do_op("ill_two",  6'b000011, 32'h7FFFFFFF, 32'h1, 5'd0, mk(32'h0, 0, 0, 0, 1), 1, 0);
    do_op("and",      C_AND, 32'hFF00FF00, 32'h0FF00FF0, 5'd0, mk(32'h0F000F00, 0, 0, 0, 0), 1, 0);

    // Abort a long shift with reset; no result may come out of it.
    ctrl_sig = C_SLL; data_a = 32'h1; shamt = 5'd20; in_valid = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clock);
    #1 reset_n = 1'b0;
    #2;
    check("abort_out_valid", out_valid, 1'b0);
    check("abort_in_ready",  in_ready,  1'b1);
    check("abort_result",    result,    32'h0);
    @(negedge clock);
    reset_n = 1'b1;
    do_op("add_after_rst", C_ADD, 32'd2, 32'd3, 5'd0, mk(32'd5, 0, 0, 0, 0), 1, 0);

    repeat (30) @(posedge clock);
    #1;
    check("no_stray_valid", out_valid, 1'b0);
    check("scoreboard_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
